// File: rtl/uart_reg_responder_if.sv
// Byte-stream handshake between a UART (master side) and the register responder (slave side).
interface uart_reg_responder_if;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;

  modport master (
    output received, rx_byte, recv_error, is_transmitting,
    input  transmit, tx_byte
  );

  modport slave (
    input  received, rx_byte, recv_error, is_transmitting,
    output transmit, tx_byte
  );
endinterface

// File: rtl/uart_reg_responder.sv
// 'W' ADDR DATA / 'R' ADDR register protocol over a UART byte stream, driving an 8-bit register bank.
// Optional inter-byte timeout in GET_ADDR/GET_DATA is enabled by defining UART_RESP_TIMEOUT_EN.
module uart_reg_responder #(
  parameter int pNumRegs       = 16,
  parameter int pTimeoutCycles = 1250000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_reg_responder_if.slave   bus,
  output logic [8*pNumRegs-1:0] regs_flat,
  output logic                  wr_pulse,
  output logic [7:0]            wr_addr
);

  localparam int         AW      = (pNumRegs > 1) ? $clog2(pNumRegs) : 1;
  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  if (pNumRegs < 1 || pNumRegs > 256) begin : g_bad_num_regs
    $error("uart_reg_responder: pNumRegs must be 1..256");
  end
  if (pTimeoutCycles < 2) begin : g_bad_timeout
    $error("uart_reg_responder: pTimeoutCycles must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_START, WAIT_DONE
  } state_t;

  state_t     state_reg;
  logic       is_write_reg;
  logic       bad_cmd_reg;
  logic [7:0] addr_reg;
  logic [7:0] data_reg;
  logic [7:0] tx_byte_reg;
  logic [7:0] regs_reg [pNumRegs];

  logic       rx_ok;
  logic       addr_in_range;
  logic       timed_out;
  logic [AW-1:0] reg_idx;

  // A framing error in the same cycle as a byte poisons that byte.
  assign rx_ok         = bus.received & ~bus.recv_error;
  assign addr_in_range = ({1'b0, addr_reg} < 9'(pNumRegs));
  assign reg_idx       = addr_reg[AW-1:0];

`ifdef UART_RESP_TIMEOUT_EN
  localparam int            TW    = $clog2(pTimeoutCycles);
  localparam logic [TW-1:0] TLAST = TW'(pTimeoutCycles - 1);

  logic [TW-1:0] timer_reg;
  logic          in_get;

  assign in_get    = (state_reg == GET_ADDR) || (state_reg == GET_DATA);
  assign timed_out = in_get && (timer_reg == TLAST);

  // Zero outside the byte-wait states, so it is already cleared whenever IDLE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if (in_get && !bus.received && !bus.recv_error && !timed_out
                 && (timer_reg != '1)) begin
      timer_reg <= timer_reg + 1'b1;
    end else begin
      timer_reg <= '0;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      is_write_reg <= 1'b0;
      bad_cmd_reg  <= 1'b0;
      addr_reg     <= 8'h00;
      data_reg     <= 8'h00;
      tx_byte_reg  <= 8'h00;
      wr_pulse     <= 1'b0;
      wr_addr      <= 8'h00;
      for (int i = 0; i < pNumRegs; i++) begin
        regs_reg[i] <= 8'h00;
      end
    end else begin
      wr_pulse <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_ok) begin
            if (bus.rx_byte == CMD_W) begin
              is_write_reg <= 1'b1;
              bad_cmd_reg  <= 1'b0;
              state_reg    <= GET_ADDR;
            end else if (bus.rx_byte == CMD_R) begin
              is_write_reg <= 1'b0;
              bad_cmd_reg  <= 1'b0;
              state_reg    <= GET_ADDR;
            end else begin
              bad_cmd_reg  <= 1'b1;
              state_reg    <= EXEC;
            end
          end
        end
        GET_ADDR: begin
          if (bus.recv_error) begin
            state_reg <= IDLE;
          end else if (bus.received) begin
            addr_reg  <= bus.rx_byte;
            state_reg <= is_write_reg ? GET_DATA : EXEC;
          end else if (timed_out) begin
            state_reg <= IDLE;
          end
        end
        GET_DATA: begin
          if (bus.recv_error) begin
            state_reg <= IDLE;
          end else if (bus.received) begin
            data_reg  <= bus.rx_byte;
            state_reg <= EXEC;
          end else if (timed_out) begin
            state_reg <= IDLE;
          end
        end
        EXEC: begin
          state_reg <= SEND;
          if (bad_cmd_reg) begin
            tx_byte_reg <= RSP_BAD;
          end else if (!addr_in_range) begin
            tx_byte_reg <= RSP_ERR;
          end else if (is_write_reg) begin
            regs_reg[reg_idx] <= data_reg;
            wr_pulse          <= 1'b1;
            wr_addr           <= addr_reg;
            tx_byte_reg       <= RSP_OK;
          end else begin
            tx_byte_reg <= regs_reg[reg_idx];
          end
        end
        SEND: begin
          if (!bus.is_transmitting) state_reg <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.is_transmitting) state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!bus.is_transmitting) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The request must appear in the same cycle the transmitter is seen idle, so it is
  // decoded from the registered state; leaving SEND on that edge bounds it to one cycle.
  assign bus.transmit = (state_reg == SEND) && !bus.is_transmitting;
  assign bus.tx_byte  = tx_byte_reg;

  for (genvar gi = 0; gi < pNumRegs; gi++) begin : g_flat
    assign regs_flat[8*gi +: 8] = regs_reg[gi];
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Randomized and directed bench for uart_reg_responder against a command-level register model.
module tb_uart_reg_responder;
  localparam int NREGS  = 16;
  localparam int TOUT   = 100;
  localparam int TX_LEN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [8*NREGS-1:0]   regs_flat;
  logic                 wr_pulse;
  logic [7:0]           wr_addr;
  uart_reg_responder_if bus();

  uart_reg_responder #(.pNumRegs(NREGS), .pTimeoutCycles(TOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .regs_flat (regs_flat),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  logic       uart_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       prev_tx = 1'b0;
  logic [7:0] reply_q[$];
  int         wr_count = 0;
  logic [7:0] last_wr_addr = 8'h00;
  int         last_rx_cyc = 0;
  logic [7:0] model_regs [NREGS];

  assign bus.is_transmitting = uart_busy | hold_busy;

  // UART transmitter stand-in: busy from the cycle after a request for TX_LEN cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.transmit === 1'b1) begin
      uart_busy <= 1'b1;
      busy_cnt  <= TX_LEN;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt  <= 0;
      uart_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.transmit === 1'b1) begin
        reply_q.push_back(bus.tx_byte);
        checks++;
        if (prev_tx === 1'b1) begin
          errors++;
          $display("FAIL transmit_consecutive: got high in cycle %0d and %0d, required single cycle", cyc - 1, cyc);
        end
      end
      if (wr_pulse === 1'b1) begin
        wr_count++;
        last_wr_addr = wr_addr;
      end
    end
    prev_tx = bus.transmit;
  end

  function automatic logic [8*NREGS-1:0] exp_flat();
    logic [8*NREGS-1:0] f;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = model_regs[i];
    return f;
  endfunction

  // Command-level reference: reply byte and write count for one complete command.
  task automatic model_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           output logic [7:0] rep, output int wrs);
    wrs = 0;
    if (b0 == 8'h57) begin
      if (b1 < NREGS) begin
        model_regs[b1] = b2;
        rep = 8'h4B;
        wrs = 1;
      end else begin
        rep = 8'h45;
      end
    end else if (b0 == 8'h52) begin
      rep = (b1 < NREGS) ? model_regs[b1] : 8'h45;
    end else begin
      rep = 8'h3F;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    bus.rx_byte  = b;
    bus.received = 1'b1;
    last_rx_cyc  = cyc;
    tick();
    bus.received = 1'b0;
  endtask

  task automatic wait_reply(input int base);
    for (int i = 0; i < 300 && reply_q.size() == base; i++) @(negedge clk);
    for (int i = 0; i < 100 && bus.is_transmitting === 1'b1; i++) @(negedge clk);
    idle(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    checks++; if (bus.transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b, required 0", bus.transmit); end
    checks++; if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h, required 00", bus.tx_byte); end
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse: got %b, required 0", wr_pulse); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h, required 00", wr_addr); end
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs: got %h, required 0", regs_flat); end
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    tick();
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_write();
    int base_r = reply_q.size();
    int base_w = wr_count;
    logic [7:0] rep, last;
    int wrs;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
    @(negedge clk);  // EXEC cycle N+1: nothing visible yet
    checks++; if (regs_flat[8*3 +: 8] !== 8'h00) begin errors++; $display("FAIL write_early: reg3 %h in N+1, required 00", regs_flat[8*3 +: 8]); end
    @(negedge clk);  // N+2
    model_cmd(8'h57, 8'h03, 8'hA5, rep, wrs);
    checks++; if (cyc != last_rx_cyc + 2) begin errors++; $display("FAIL write_cycle: at %0d, required %0d", cyc, last_rx_cyc + 2); end
    checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL write_regs: got %h, required %h", regs_flat, exp_flat()); end
    checks++; if (wr_pulse !== 1'b1 || wr_addr !== 8'h03) begin errors++; $display("FAIL write_pulse: pulse %b addr %h, required 1 03", wr_pulse, wr_addr); end
    checks++; if (bus.transmit !== 1'b1) begin errors++; $display("FAIL write_transmit_n2: got %b, required 1", bus.transmit); end
    wait_reply(base_r);
    last = (reply_q.size() > base_r) ? reply_q[$] : 8'hxx;
    checks++; if (reply_q.size() != base_r + 1) begin errors++; $display("FAIL write_reply_count: got %0d, required 1", reply_q.size() - base_r); end
    checks++; if (last !== rep) begin errors++; $display("FAIL write_reply: got %h, required %h", last, rep); end
    checks++; if (wr_count - base_w != wrs) begin errors++; $display("FAIL write_pulses: got %0d, required %0d", wr_count - base_w, wrs); end
    $display("write 57 03 A5 -> reply %h", last);
  endtask

  task automatic test_read();
    int base_r = reply_q.size();
    int base_w = wr_count;
    logic [7:0] rep, last;
    int wrs;
    send_byte(8'h52); send_byte(8'h03);
    model_cmd(8'h52, 8'h03, 8'h00, rep, wrs);
    wait_reply(base_r);
    last = (reply_q.size() > base_r) ? reply_q[$] : 8'hxx;
    checks++; if (reply_q.size() != base_r + 1) begin errors++; $display("FAIL read_reply_count: got %0d, required 1", reply_q.size() - base_r); end
    checks++; if (last !== rep) begin errors++; $display("FAIL read_reply: got %h, required %h", last, rep); end
    checks++; if (wr_count != base_w) begin errors++; $display("FAIL read_no_write: got %0d pulses, required 0", wr_count - base_w); end
    $display("read 52 03 -> reply %h", last);
  endtask

  task automatic test_errors();
    int base_r = reply_q.size();
    int base_w = wr_count;
    logic [7:0] rep, last;
    int wrs;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h11);
    model_cmd(8'h57, 8'h10, 8'h11, rep, wrs);
    wait_reply(base_r);
    last = (reply_q.size() > base_r) ? reply_q[$] : 8'hxx;
    checks++; if (last !== rep) begin errors++; $display("FAIL range_reply: got %h, required %h", last, rep); end
    checks++; if (wr_count != base_w) begin errors++; $display("FAIL range_no_write: got %0d pulses, required 0", wr_count - base_w); end
    checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL range_regs: got %h, required %h", regs_flat, exp_flat()); end
    $display("write 57 10 11 -> reply %h", last);
    base_r = reply_q.size();
    send_byte(8'h41);
    model_cmd(8'h41, 8'h00, 8'h00, rep, wrs);
    wait_reply(base_r);
    last = (reply_q.size() > base_r) ? reply_q[$] : 8'hxx;
    checks++; if (last !== rep) begin errors++; $display("FAIL unknown_reply: got %h, required %h", last, rep); end
    $display("unknown 41 -> reply %h", last);
  endtask

  task automatic test_busy_hold();
    int base_r = reply_q.size();
    int seen = 0;
    logic [7:0] rep;
    int wrs;
    hold_busy = 1'b1;
    send_byte(8'h52); send_byte(8'h03);
    model_cmd(8'h52, 8'h03, 8'h00, rep, wrs);
    repeat (50) begin
      @(negedge clk);
      if (bus.transmit === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL busy_wait: transmit seen %0d cycles, required 0", seen); end
    tick();
    hold_busy = 1'b0;
    @(negedge clk);
    checks++; if (bus.transmit !== 1'b1 || bus.tx_byte !== rep) begin errors++; $display("FAIL busy_release: transmit %b byte %h, required 1 %h", bus.transmit, bus.tx_byte, rep); end
    for (int i = 0; i < 20 && bus.is_transmitting !== 1'b1; i++) @(negedge clk);
    send_byte(8'h41);  // lands in WAIT_DONE and must be dropped
    wait_reply(base_r);
    idle(20);
    checks++; if (reply_q.size() != base_r + 1) begin errors++; $display("FAIL busy_replies: got %0d, required 1", reply_q.size() - base_r); end
    $display("held-busy read 52 03 -> %0d replies", reply_q.size() - base_r);
  endtask

  task automatic test_abort();
    int base_r = reply_q.size();
    int base_w = wr_count;
    logic [7:0] rep, last;
    int wrs;
    send_byte(8'h57); send_byte(8'h02);
    bus.recv_error = 1'b1;
    tick();
    bus.recv_error = 1'b0;
    idle(30);
    checks++; if (reply_q.size() != base_r) begin errors++; $display("FAIL abort_reply: got %0d replies, required 0", reply_q.size() - base_r); end
    checks++; if (wr_count != base_w) begin errors++; $display("FAIL abort_write: got %0d pulses, required 0", wr_count - base_w); end
    send_byte(8'h52); send_byte(8'h02);
    model_cmd(8'h52, 8'h02, 8'h00, rep, wrs);
    wait_reply(base_r);
    last = (reply_q.size() > base_r) ? reply_q[$] : 8'hxx;
    checks++; if (last !== rep) begin errors++; $display("FAIL abort_readback: got %h, required %h", last, rep); end
    $display("abort then read 52 02 -> reply %h", last);
  endtask

  task automatic test_timeout();
    int base_r = reply_q.size();
    logic [7:0] rep, last;
    int wrs;
    send_byte(8'h57);
`ifdef UART_RESP_TIMEOUT_EN
    idle(TOUT + 5);
    send_byte(8'h52); send_byte(8'h00);
    model_cmd(8'h52, 8'h00, 8'h00, rep, wrs);
`else
    idle(2 * TOUT);
    send_byte(8'h05); send_byte(8'h77);
    model_cmd(8'h57, 8'h05, 8'h77, rep, wrs);
`endif
    wait_reply(base_r);
    last = (reply_q.size() > base_r) ? reply_q[$] : 8'hxx;
    checks++; if (last !== rep) begin errors++; $display("FAIL timeout_reply: got %h, required %h", last, rep); end
    checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL timeout_regs: got %h, required %h", regs_flat, exp_flat()); end
    $display("late-byte command -> reply %h", last);
  endtask

  task automatic test_random();
    logic [7:0] b0, b1, b2, rep, last;
    int n, wrs, base_r, base_w;
    for (int t = 0; t < 24; t++) begin
      base_r = reply_q.size();
      base_w = wr_count;
      case ($urandom_range(0, 2))
        0: begin b0 = 8'h57; n = 3; end
        1: begin b0 = 8'h52; n = 2; end
        default: begin
          do b0 = 8'($urandom); while (b0 == 8'h57 || b0 == 8'h52);
          n = 1;
        end
      endcase
      b1 = 8'($urandom_range(0, NREGS + 3));
      b2 = 8'($urandom);
      send_byte(b0);
      if (n > 1) begin idle($urandom_range(0, 3)); send_byte(b1); end
      if (n > 2) begin idle($urandom_range(0, 3)); send_byte(b2); end
      model_cmd(b0, b1, b2, rep, wrs);
      wait_reply(base_r);
      last = (reply_q.size() > base_r) ? reply_q[$] : 8'hxx;
      checks++; if (last !== rep || reply_q.size() != base_r + 1) begin errors++; $display("FAIL rand_reply[%0d]: got %h x%0d, required %h x1", t, last, reply_q.size() - base_r, rep); end
      checks++; if (wr_count - base_w != wrs) begin errors++; $display("FAIL rand_pulses[%0d]: got %0d, required %0d", t, wr_count - base_w, wrs); end
      checks++; if (regs_flat !== exp_flat()) begin errors++; $display("FAIL rand_regs[%0d]: got %h, required %h", t, regs_flat, exp_flat()); end
      if (wrs != 0) begin
        checks++; if (last_wr_addr !== b1) begin errors++; $display("FAIL rand_wr_addr[%0d]: got %h, required %h", t, last_wr_addr, b1); end
      end
      $display("rand %0d: cmd %h %h %h n=%0d -> reply %h", t, b0, b1, b2, n, last);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.received   = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.recv_error = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_busy_hold();
    test_abort();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
